// File: rtl/pager_pkg.sv
// Shared types and helpers for the product pager: FSM states, display geometry
// and the leading-zero blank mask used to darken unused digits.
package pager_pkg;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_LO = 2'd1,
        SHOW_HI = 2'd2
    } pager_state_t;

    // Bit k is set when nibble k and every more significant nibble are zero.
    function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [WORD_W-1:0] word);
        logic [DIGITS-1:0] mask;
        logic              all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (word[k*NIBBLE_W +: NIBBLE_W] == '0);
            mask[k]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: two-FF synchronizer plus a restartable stability counter.
// Emits the accepted pressed level and a one-cycle pulse on each accepted press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int                CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] count_reg;
    logic             sample;

    assign sample = ~sync2_reg;

    // The count only tracks consecutive samples that disagree with the accepted
    // level; it is cleared on acceptance, so it saturates at LAST and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            count_reg <= '0;
            pressed   <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press     <= 1'b0;
            if (sample == pressed) begin
                count_reg <= '0;
            end else if (count_reg >= LAST) begin
                count_reg <= '0;
                pressed   <= sample;
                press     <= sample;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/product_pager.sv
// Captures the multiplier product on done's rising edge and pages its low/high
// word onto an 8-digit display, with per-digit leading-zero blank flags.
module product_pager
    import pager_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PRODUCT_W       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done,
    input  logic [PRODUCT_W-1:0] product,
    input  logic                 page_key_n,
    input  logic                 blank_en,
    output logic [WORD_W-1:0]    show_word,
    output logic [DIGITS-1:0]    digit_blank,
    output logic                 upper_sel,
    output logic                 captured
);

    localparam logic [DIGITS-1:0] RESET_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};

    logic                 done_q_reg;
    logic [PRODUCT_W-1:0] cap_reg;
    pager_state_t         state_reg;
    pager_state_t         state_next;
    logic                 capture;
    logic                 key_pressed;
    logic                 key_press;
    logic                 page_req;
    logic [WORD_W-1:0]    hi_word;
    logic [WORD_W-1:0]    lo_word;
    logic [WORD_W-1:0]    word_next;
    logic [DIGITS-1:0]    blank_next;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (page_key_n),
        .pressed(key_pressed),
        .press  (key_press)
    );

    assign capture  = done & ~done_q_reg;
    // The pulse and the accepted level rise together; both must agree to page.
    assign page_req = key_press & key_pressed;
    assign hi_word  = cap_reg[PRODUCT_W-1:WORD_W];
    assign lo_word  = cap_reg[WORD_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q_reg <= 1'b0;
            cap_reg    <= '0;
            state_reg  <= IDLE;
        end else begin
            done_q_reg <= done;
            if (capture) begin
                cap_reg <= product;
            end
            state_reg <= state_next;
        end
    end

    // A fresh capture always returns to the low word, overriding a same-cycle press.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture) state_next = SHOW_LO;
            SHOW_LO: if (capture) state_next = SHOW_LO;
                     else if (page_req) state_next = SHOW_HI;
            SHOW_HI: if (capture || page_req) state_next = SHOW_LO;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        word_next  = '0;
        blank_next = '0;
        if (state_reg == SHOW_HI) begin
            word_next = hi_word;
        end else if (state_reg == SHOW_LO) begin
            word_next = lo_word;
        end
        if (blank_en) begin
            if (state_reg == SHOW_HI) begin
                blank_next = lz_blank_mask(hi_word);
            end else if (hi_word == '0) begin
                // Keep digit 0 lit so a zero value reads as "0".
                blank_next = lz_blank_mask(lo_word) & RESET_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_word   <= '0;
            digit_blank <= RESET_BLANK;
            upper_sel   <= 1'b0;
            captured    <= 1'b0;
        end else begin
            show_word   <= word_next;
            digit_blank <= blank_next;
            upper_sel   <= (state_reg == SHOW_HI);
            captured    <= (state_reg != IDLE);
        end
    end

endmodule
